cs_packet_builder: RTL and testbench
====================================

CS_PACKET_BUILDER -- requirements
Module: cs_packet_builder

Interface
REQ-001 SHALL take DATA_WIDTH, REG_BANK_DEPTH and PACKET_LEN (= DATA_WIDTH*REG_BANK_DEPTH) from cs_constants.v, with no module parameters; there is one clock, and reset is asynchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream sample valid.
REQ-005 in_ready  out  1  builder can accept a sample this cycle.
REQ-006 in_data  in  DATA_WIDTH  unsigned sample.
REQ-007 in_sof  in  1  start-of-frame flag, meaningful on the first beat of a packet only.
REQ-008 out_valid  out  1  packet and predictors valid.
REQ-009 out_ready  in  1  downstream subtractor stage accepts.
REQ-010 out_packet  out  PACKET_LEN  lane i at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-011 out_b_0  out  DATA_WIDTH  lane-0 predictor.
REQ-012 out_b  out  DATA_WIDTH  predictor for lanes 1..REG_BANK_DEPTH-1.

Function
REQ-013 A beat SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; the k-th accepted beat of a packet (k=0..REG_BANK_DEPTH-1) SHALL be written into lane k of the assembly bank.
REQ-014 The FSM SHALL have two states, FILL and PEND; in_ready SHALL be 1 only in FILL and only while rst is low.
REQ-015 FILL: beat counter SHALL increment per accepted beat; acceptance of beat REG_BANK_DEPTH-1 SHALL clear the counter and move the FSM to PEND.
REQ-016 PEND: when the output register is free (out_valid=0, or out_valid=1 and out_ready=1 in the same cycle), the next edge SHALL load out_packet from the bank, set out_valid=1 and return the FSM to FILL; otherwise the FSM SHALL remain in PEND.
REQ-017 Latency: out_valid SHALL rise on the edge immediately after the last-beat edge when the output is free; best-case throughput SHALL be one packet per REG_BANK_DEPTH+1 cycles.
REQ-018 out_valid SHALL drop on an edge with out_ready=1 and no simultaneous load; out_packet, out_b_0 and out_b SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 A simultaneous drain and load SHALL keep out_valid=1 with the new contents and no bubble.
REQ-020 Running sum: an accumulator of width DATA_WIDTH+log2(REG_BANK_DEPTH) SHALL sum the current packet's samples without overflow; REG_BANK_DEPTH SHALL be a power of two.
REQ-021 On load: out_b_0 SHALL take prev_last and out_b SHALL take prev_mean; then prev_last SHALL take bank lane REG_BANK_DEPTH-1 and prev_mean SHALL take floor(sum/REG_BANK_DEPTH), computed as a right shift; the accumulator SHALL then clear.
REQ-022 A packet whose beat 0 carried in_sof=1 SHALL load out_b_0=0 and out_b=0 regardless of prev_*; in_sof on beats 1..REG_BANK_DEPTH-1 SHALL be ignored.
REQ-023 Samples SHALL be treated as unsigned; no saturation is needed because the mean is at most 2^DATA_WIDTH-1.

Reset
REQ-024 While rst=1: FSM=FILL, counter=0, accumulator=0, prev_last=0, prev_mean=0, out_valid=0, out_packet=0, out_b_0=0, out_b=0, in_ready=0.
REQ-025 Reset asserted mid-packet or while out_valid=1 SHALL discard the partial and pending packets; the first packet after reset SHALL see predictors 0.

Structure
REQ-026 A REG_BANK_LOG2 constant SHALL be added to cs_constants.v; the FSM state encodings SHALL also live there.
REQ-027 The sum/shift logic SHALL be one sub-module, cs_mean_accum (ports: clk, rst, clear, add_en, sample, mean).

Verification (DATA_WIDTH=8, REG_BANK_DEPTH=4)
REQ-028 Stimulus: 10,20,30,40 with sof, out_ready=1 -> out_packet=0x281E140A, b_0=0, b=0, out_valid exactly 1 cycle after last beat.
REQ-029 Stimulus: then 1,2,3,4 without sof -> out_packet=0x04030201, b_0=40, b=25.
REQ-030 Stimulus: 255 x4, then 255 x4 -> second packet b=255 (sum 1020, no wrap), b_0=255.
REQ-031 Stimulus: out_ready=0 with a second packet completed -> FSM holds PEND, in_ready=0, first packet stable; out_ready=1 -> drain and load on the same edge, second packet follows with no bubble.
REQ-032 Stimulus: rst pulse after 2 beats, then 5,6,7,8 -> out_packet=0x08070605, b_0=0, b=0.
REQ-033 Stimulus: in_sof=1 on beat 2 of a non-first packet -> predictors come from the previous packet.

Source files
------------

// File: rtl/cs_packet_builder_pkg.sv
// Shared constants and FSM encodings for the packet builder and its helpers.
// REG_BANK_DEPTH must stay a power of two (>= 2) so the mean is a plain shift.
package cs_packet_builder_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_BANK_DEPTH = 4;
    localparam int REG_BANK_LOG2  = 2;
    localparam int PACKET_LEN     = DATA_WIDTH * REG_BANK_DEPTH;
    localparam int SUM_WIDTH      = DATA_WIDTH + REG_BANK_LOG2;

    // FILL collects beats; PEND waits for the output register to free up.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/cs_packet_builder_mean_accum.sv
// Running sum of the current packet's samples; the mean is the sum shifted
// right by log2(depth). The sum is wide enough that it never wraps.
module cs_mean_accum
    import cs_packet_builder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] mean
);

    logic [SUM_WIDTH-1:0] sum_reg;
    logic [SUM_WIDTH-1:0] sum_shifted;

    // Accumulate accepted samples; a clear that coincides with an add restarts
    // the sum at that sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= add_en ? SUM_WIDTH'(sample) : '0;
        end else if (add_en) begin
            sum_reg <= sum_reg + SUM_WIDTH'(sample);
        end
    end

    // floor(sum / depth) always fits back into DATA_WIDTH bits.
    always_comb begin
        sum_shifted = sum_reg >> REG_BANK_LOG2;
        mean        = sum_shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/cs_packet_builder.sv
// Assembles REG_BANK_DEPTH samples into one wide packet and attaches two
// predictors derived from the previous packet (its last sample and its mean).
module cs_packet_builder
    import cs_packet_builder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACKET_LEN-1:0] out_packet,
    output logic [DATA_WIDTH-1:0] out_b_0,
    output logic [DATA_WIDTH-1:0] out_b
);

    state_t                     state_reg;
    state_t                     state_next;
    logic [REG_BANK_LOG2-1:0]   cnt_reg;
    logic                       sof_reg;
    logic [DATA_WIDTH-1:0]      bank_reg [REG_BANK_DEPTH];
    logic [PACKET_LEN-1:0]      bank_flat;
    logic [DATA_WIDTH-1:0]      prev_last_reg;
    logic [DATA_WIDTH-1:0]      prev_mean_reg;
    logic [DATA_WIDTH-1:0]      mean;
    logic                       out_valid_reg;
    logic [PACKET_LEN-1:0]      out_packet_reg;
    logic [DATA_WIDTH-1:0]      out_b_0_reg;
    logic [DATA_WIDTH-1:0]      out_b_reg;
    logic                       accept;
    logic                       load;
    logic                       last_beat;

    assign last_beat = (cnt_reg == REG_BANK_LOG2'(REG_BANK_DEPTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, handshake and load strobe; in_ready is held low during reset.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_FILL: begin
                in_ready = ~rst;
                accept   = in_valid & ~rst;
                if (accept && last_beat) begin
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!out_valid_reg || out_ready) begin
                    load       = 1'b1;
                    state_next = ST_FILL;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Beat counter and the start-of-frame flag captured from beat 0 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            sof_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
            if (cnt_reg == '0) begin
                sof_reg <= in_sof;
            end
        end
    end

    // One register per lane; lane gi captures the gi-th accepted beat.
    genvar gi;
    generate
        for (gi = 0; gi < REG_BANK_DEPTH; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bank_reg[gi] <= '0;
                end else if (accept && (cnt_reg == REG_BANK_LOG2'(gi))) begin
                    bank_reg[gi] <= in_data;
                end
            end
            assign bank_flat[DATA_WIDTH*gi +: DATA_WIDTH] = bank_reg[gi];
        end
    endgenerate

    cs_mean_accum u_mean_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (load),
        .add_en (accept),
        .sample (in_data),
        .mean   (mean)
    );

    // Output register: load has priority over drain, so a drain and load on
    // the same edge keeps out_valid high with the new packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_packet_reg <= '0;
            out_b_0_reg    <= '0;
            out_b_reg      <= '0;
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            out_packet_reg <= bank_flat;
            out_b_0_reg    <= sof_reg ? '0 : prev_last_reg;
            out_b_reg      <= sof_reg ? '0 : prev_mean_reg;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    // Predictor history, refreshed from the packet being loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_last_reg <= '0;
            prev_mean_reg <= '0;
        end else if (load) begin
            prev_last_reg <= bank_reg[REG_BANK_DEPTH-1];
            prev_mean_reg <= mean;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_packet = out_packet_reg;
    assign out_b_0    = out_b_0_reg;
    assign out_b      = out_b_reg;

endmodule

// File: tb/tb_cs_packet_builder.sv
// Directed bench for cs_packet_builder (8-bit samples, 4 lanes): a vector
// table of whole packets plus hand sequences for backpressure and reset.
module tb_cs_packet_builder;
    import cs_packet_builder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_packet;
    logic [7:0]  out_b_0;
    logic [7:0]  out_b;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] beats;     // beat k in bits [8k +: 8]
        logic [3:0]  sof_mask;  // in_sof value driven on beat k
        logic [31:0] exp_pkt;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t vecs [6];

    cs_packet_builder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .out_b_0    (out_b_0),
        .out_b      (out_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        chk("in_ready_on_beat", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic end_beats();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_packet(input logic [31:0] beats, input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            send_beat(beats[8*k +: 8], mask[k]);
        end
        end_beats();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"sof_first",   32'h281E140A, 4'b0001, 32'h281E140A, 8'd0,   8'd0};
        vecs[1] = '{"no_sof",      32'h04030201, 4'b0000, 32'h04030201, 8'd40,  8'd25};
        vecs[2] = '{"max_a",       32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF, 8'd4,   8'd2};
        vecs[3] = '{"max_b",       32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF, 8'd255, 8'd255};
        vecs[4] = '{"late_sof",    32'h06070809, 4'b0100, 32'h06070809, 8'd255, 8'd255};
        vecs[5] = '{"sof_restart", 32'h64000000, 4'b0001, 32'h64000000, 8'd0,   8'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",   {31'd0, in_ready},  32'd0);
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_packet", out_packet,         32'd0);
        chk("rst_out_b_0",    {24'd0, out_b_0},   32'd0);
        chk("rst_out_b",      {24'd0, out_b},     32'd0);
        rst = 1'b0;

        // Table: each packet drained immediately; out_valid rises exactly one
        // cycle after the last beat and falls one cycle later.
        for (int i = 0; i < 6; i++) begin
            send_packet(vecs[i].beats, vecs[i].sof_mask);
            chk({vecs[i].name, "_valid_early"}, {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({vecs[i].name, "_packet"}, out_packet, vecs[i].exp_pkt);
            chk({vecs[i].name, "_b_0"}, {24'd0, out_b_0}, {24'd0, vecs[i].exp_b0});
            chk({vecs[i].name, "_b"}, {24'd0, out_b}, {24'd0, vecs[i].exp_b});
            @(negedge clk);
            chk({vecs[i].name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: P1 held, P2 completes and waits in PEND, then a
        // single edge drains P1 and loads P2. History: last=100, mean=25.
        out_ready = 1'b0;
        send_packet(32'h0E0D0C0B, 4'b0000);
        @(negedge clk);
        chk("bp_p1_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_p1_packet", out_packet, 32'h0E0D0C0B);
        chk("bp_p1_b_0", {24'd0, out_b_0}, 32'd100);
        chk("bp_p1_b", {24'd0, out_b}, 32'd25);
        send_packet(32'h18171615, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_packet", out_packet, 32'h0E0D0C0B);
            chk("bp_hold_b_0", {24'd0, out_b_0}, 32'd100);
            chk("bp_hold_b", {24'd0, out_b}, 32'd25);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_p2_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_p2_packet", out_packet, 32'h18171615);
        chk("bp_p2_b_0", {24'd0, out_b_0}, 32'd14);
        chk("bp_p2_b", {24'd0, out_b}, 32'd12);
        chk("bp_p2_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_p2_valid_drop", {31'd0, out_valid}, 32'd0);

        // Reset with a packet held on the output and a partial in the bank.
        // History before: last=24, mean=22.
        out_ready = 1'b0;
        send_packet(32'h01010101, 4'b0000);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_b_0", {24'd0, out_b_0}, 32'd24);
        chk("pre_rst_b", {24'd0, out_b}, 32'd22);
        send_beat(8'd50, 1'b0);
        send_beat(8'd60, 1'b0);
        end_beats();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_packet", out_packet, 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        send_packet(32'h08070605, 4'b0000);
        chk("post_rst_valid_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_packet", out_packet, 32'h08070605);
        chk("post_rst_b_0", {24'd0, out_b_0}, 32'd0);
        chk("post_rst_b", {24'd0, out_b}, 32'd0);
        @(negedge clk);
        chk("post_rst_valid_drop", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
